// File: rtl/acp_burst_reader.sv
// AXI4 INCR burst read engine: splits (addr, beats) commands into 4 KB-safe bursts on the ACP read channel.
// Latency: a returned R beat appears on the stream one cycle after it is written into the return FIFO.
// Backpressure: m_tready stalls the FIFO; new bursts issue only when free FIFO credits cover the whole burst.
module acp_burst_reader #(
    parameter int DATA_W     = 64,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_addr,
    input  logic [15:0]       cmd_beats,
    output logic              done,
    output logic              err,

    output logic [31:0]       M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic [3:0]        M_AXI_ARCACHE,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,

    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             state;
    logic               alive;
    logic               done_q;
    logic [28:0]        addr_q;        // 8-byte word address of the next burst
    logic [15:0]        remaining;
    logic [15:0]        total_beats;
    logic [15:0]        rx_cnt;
    logic [CNT_W-1:0]   reserved;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [DATA_W:0]    mem [FIFO_DEPTH];

    logic               ar_hs;
    logic               r_hs;
    logic               s_hs;
    logic               ar_raise;
    logic               fifo_full;
    logic               rx_last;
    logic [16:0]        room;
    logic [16:0]        len;
    logic [16:0]        credit;
    logic [CNT_W-1:0]   res_add;
    logic [CNT_W-1:0]   res_sub;

    // Unconsumed inputs: framing comes from the beat counter, and the address is beat aligned.
    logic unused_in;
    assign unused_in = ^{M_AXI_RLAST, cmd_addr[2:0]};

    assign M_AXI_ARSIZE  = 3'b011;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARCACHE = 4'b1111;
    assign M_AXI_ARPROT  = 3'b000;

    assign fifo_full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign M_AXI_RREADY = alive && !fifo_full;
    assign m_tvalid     = (fifo_cnt != '0);
    assign m_tdata      = m_tvalid ? mem[rd_ptr][DATA_W:1] : '0;
    assign m_tlast      = m_tvalid && mem[rd_ptr][0];

    assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;
    assign s_hs    = m_tvalid && m_tready;
    assign rx_last = ((rx_cnt + 16'd1) == total_beats);
    assign done    = done_q || ((state == S_DRAIN) && s_hs && m_tlast);

    // Burst length is capped by the command, the burst limit and the distance to the next 4 KB page.
    always_comb begin
        room = 17'd512 - 17'(addr_q[8:0]);
        len  = {1'b0, remaining};
        if (len > 17'(MAX_BURST)) begin
            len = 17'(MAX_BURST);
        end
        if (len > room) begin
            len = room;
        end
        credit   = 17'(FIFO_DEPTH) - 17'(fifo_cnt) - 17'(reserved);
        ar_raise = (state == S_ISSUE) && !M_AXI_ARVALID && (remaining != 16'd0) && (credit >= len);
        res_add  = ar_raise ? CNT_W'(len) : '0;
        res_sub  = r_hs ? CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            alive         <= 1'b0;
            cmd_ready     <= 1'b0;
            done_q        <= 1'b0;
            err           <= 1'b0;
            addr_q        <= '0;
            remaining     <= '0;
            total_beats   <= '0;
            rx_cnt        <= '0;
            reserved      <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
        end else begin
            alive    <= 1'b1;
            done_q   <= 1'b0;
            reserved <= reserved + res_add - res_sub;

            if (r_hs) begin
                rx_cnt <= rx_cnt + 16'd1;
                if (M_AXI_RRESP != 2'b00) begin
                    err <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        addr_q      <= cmd_addr[31:3];
                        remaining   <= cmd_beats;
                        total_beats <= cmd_beats;
                        rx_cnt      <= '0;
                        err         <= 1'b0;
                        if (cmd_beats == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    // Address and length are captured on raise, so they stay frozen until ARREADY.
                    if (ar_raise) begin
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_ARADDR  <= {addr_q, 3'b000};
                        M_AXI_ARLEN   <= 8'(len - 17'd1);
                    end else if (ar_hs) begin
                        M_AXI_ARVALID <= 1'b0;
                        addr_q        <= addr_q + 29'(len);
                        remaining     <= remaining - 16'(len);
                        if (remaining == 16'(len)) begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (s_hs && m_tlast) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Return FIFO pointers and occupancy; no write-to-read bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (r_hs) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (s_hs) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({r_hs, s_hs})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_hs) begin
            mem[wr_ptr] <= {M_AXI_RDATA, rx_last};
        end
    end

endmodule

// File: tb/tb_acp_burst_reader.sv
// Self-checking bench for acp_burst_reader: random AXI slave and stream sink against a queue-based reference model.
module tb_acp_burst_reader;

    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        done;
    logic        err;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [63:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    acp_burst_reader #(
        .DATA_W(64),
        .MAX_BURST(MAX_BURST),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats),
        .done(done),
        .err(err),
        .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARCACHE(M_AXI_ARCACHE),
        .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    int checks = 0;
    int errors = 0;

    ar_t         exp_ar[$];
    ar_t         sl_q[$];
    ar_t         ar_log[$];
    logic [64:0] exp_dq[$];

    bit  fast_mode = 1'b1;
    int  stall_cyc = 0;
    int  err_beat = 0;
    int  cmd_rbeats = 0;
    bit  exp_err = 1'b0;
    int  out_beats = 0;
    int  rcvd = 0;
    int  streamed = 0;
    int  done_cnt = 0;
    int  ar_cnt = 0;
    int  rready_viol = 0;
    int  credit_viol = 0;
    int  hold_viol = 0;
    logic [31:0] cur_addr = '0;
    int  cur_left = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a);
        return {a ^ 32'h5A5A_1234, a};
    endfunction

    // AXI slave, stream sink and protocol monitor; samples on negedge, acts just after posedge.
    initial begin : bus_model
        logic        s_ar, s_r, s_s, s_done, s_tlast;
        logic [31:0] s_araddr;
        logic [7:0]  s_arlen;
        logic [1:0]  s_rresp;
        logic [63:0] s_tdata;
        logic        prev_stall;
        logic [63:0] prev_data;
        logic        prev_last;
        ar_t         e;
        logic [64:0] d;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        m_tready      = 1'b0;
        forever begin
            @(negedge clk);
            s_ar     = M_AXI_ARVALID && M_AXI_ARREADY;
            s_araddr = M_AXI_ARADDR;
            s_arlen  = M_AXI_ARLEN;
            s_r      = M_AXI_RVALID && M_AXI_RREADY;
            s_rresp  = M_AXI_RRESP;
            s_s      = m_tvalid && m_tready;
            s_tdata  = m_tdata;
            s_tlast  = m_tlast;
            s_done   = done;
            if (rst_n) begin
                if (out_beats > 0 && !M_AXI_RREADY) rready_viol++;
                if (out_beats + (rcvd - streamed) + (M_AXI_ARVALID ? int'(M_AXI_ARLEN) + 1 : 0) > FIFO_DEPTH)
                    credit_viol++;
                if (prev_stall && !(m_tvalid && m_tdata == prev_data && m_tlast == prev_last)) hold_viol++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;

            @(posedge clk);
            #1;
            if (s_ar) begin
                if (exp_ar.size() == 0) begin
                    check_eq("ar_unexpected", 1, 0);
                end else begin
                    e = exp_ar.pop_front();
                    check_eq("araddr", s_araddr, e.addr);
                    check_eq("arlen", s_arlen, e.len);
                end
                e.addr = s_araddr;
                e.len  = s_arlen;
                sl_q.push_back(e);
                ar_log.push_back(e);
                out_beats += int'(s_arlen) + 1;
                ar_cnt++;
            end
            if (s_r) begin
                out_beats--;
                rcvd++;
                cmd_rbeats++;
                if (s_rresp != 2'b00) exp_err = 1'b1;
                check_eq("err_sticky", err, exp_err);
                cur_addr += 32'd8;
                cur_left--;
            end
            if (s_s) begin
                streamed++;
                if (exp_dq.size() == 0) begin
                    check_eq("extra_beat", 1, 0);
                end else begin
                    d = exp_dq.pop_front();
                    check_eq("tdata", s_tdata, d[64:1]);
                    check_eq("tlast", s_tlast, d[0]);
                end
            end
            if (s_done) done_cnt++;

            if (s_r || !M_AXI_RVALID) begin
                M_AXI_RVALID = 1'b0;
                if (cur_left == 0 && sl_q.size() > 0) begin
                    e = sl_q.pop_front();
                    cur_addr = e.addr;
                    cur_left = int'(e.len) + 1;
                end
                if (cur_left > 0 && (fast_mode || $urandom_range(0, 3) != 0)) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA  = beat_data(cur_addr);
                    M_AXI_RRESP  = (cmd_rbeats + 1 == err_beat) ? 2'b10 : 2'b00;
                    M_AXI_RLAST  = (cur_left == 1);
                end
            end
            M_AXI_ARREADY = fast_mode || ($urandom_range(0, 2) != 0);
            if (stall_cyc > 0) begin
                stall_cyc--;
                m_tready = 1'b0;
            end else begin
                m_tready = fast_mode || ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic run_cmd(input logic [31:0] addr, input int beats, input bit fast, input int stall, input int eb);
        logic [31:0] a;
        int rem, len, room, nb, d0, a0, n;
        bit acc;
        ar_t e;
        a   = addr & ~32'h7;
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 8;
            len  = rem;
            if (len > MAX_BURST) len = MAX_BURST;
            if (len > room) len = room;
            e.addr = a;
            e.len  = 8'(len - 1);
            exp_ar.push_back(e);
            a   += 32'(len * 8);
            rem -= len;
        end
        nb = exp_ar.size();
        for (int i = 0; i < beats; i++)
            exp_dq.push_back({beat_data((addr & ~32'h7) + 32'(i * 8)), i == beats - 1});
        ar_log.delete();
        d0 = done_cnt;
        a0 = ar_cnt;
        fast_mode  = fast;
        err_beat   = eb;
        cmd_rbeats = 0;
        exp_err    = 1'b0;
        cmd_addr   = addr;
        cmd_beats  = 16'(beats);
        cmd_valid  = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        stall_cyc = stall;
        check_eq("accept", acc, 1);
        check_eq("cmd_ready_busy", cmd_ready, 0);
        check_eq("err_clear", err, 0);
        if (beats == 0) begin
            check_eq("zero_done", done, 1);
            check_eq("zero_arvalid", M_AXI_ARVALID, 0);
            @(posedge clk);
            #1;
            check_eq("zero_done_drop", done, 0);
            check_eq("zero_ready", cmd_ready, 1);
        end else begin
            n = 0;
            while (done_cnt == d0 && n < 5000) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        repeat (3) @(posedge clk);
        #2;
        check_eq("done_once", 64'(done_cnt - d0), 1);
        check_eq("ar_count", 64'(ar_cnt - a0), 64'(nb));
        check_eq("ar_left", 64'(exp_ar.size()), 0);
        check_eq("beats_left", 64'(exp_dq.size()), 0);
        check_eq("err_final", err, (eb != 0 && eb <= beats));
        check_eq("ready_after", cmd_ready, 1);
        exp_ar.delete();
        exp_dq.delete();
    endtask

    task automatic check_s1_log();
        check_eq("s1_nbursts", 64'(ar_log.size()), 3);
        if (ar_log.size() == 3) begin
            check_eq("s1_a0", ar_log[0].addr, 32'h1000_0000);
            check_eq("s1_l0", ar_log[0].len, 8'd15);
            check_eq("s1_a1", ar_log[1].addr, 32'h1000_0080);
            check_eq("s1_l1", ar_log[1].len, 8'd15);
            check_eq("s1_a2", ar_log[2].addr, 32'h1000_0100);
            check_eq("s1_l2", ar_log[2].len, 8'd7);
        end
    endtask

    initial begin : main
        int b;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_arvalid", M_AXI_ARVALID, 0);
        check_eq("rst_rready", M_AXI_RREADY, 0);
        check_eq("rst_tvalid", m_tvalid, 0);
        check_eq("rst_done_err", {done, err}, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_rst_ready", cmd_ready, 1);
        check_eq("const_ar", {M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARPROT}, {3'b011, 2'b01, 4'b1111, 3'b000});

        run_cmd(32'h1000_0000, 40, 1'b1, 0, 0);
        check_s1_log();
        run_cmd(32'h1000_0FC0, 16, 1'b1, 0, 0);
        check_eq("s2_nbursts", 64'(ar_log.size()), 2);
        if (ar_log.size() == 2) begin
            check_eq("s2_a0", ar_log[0].addr, 32'h1000_0FC0);
            check_eq("s2_l0", ar_log[0].len, 8'd7);
            check_eq("s2_a1", ar_log[1].addr, 32'h1000_1000);
            check_eq("s2_l1", ar_log[1].len, 8'd7);
        end
        run_cmd(32'h1000_0000, 40, 1'b1, 100, 0);
        check_s1_log();
        run_cmd(32'h2000_0000, 0, 1'b1, 0, 0);
        run_cmd(32'h3000_0100, 8, 1'b0, 0, 5);
        for (int k = 0; k < 6; k++) begin
            b = $urandom_range(1, 100);
            run_cmd($urandom, b, 1'b0, ($urandom_range(0, 2) == 0) ? $urandom_range(10, 60) : 0,
                    (k == 5) ? $urandom_range(1, b) : 0);
        end

        repeat ($urandom_range(1, 5)) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_cmd_ready", cmd_ready, 0);
        check_eq("arst_err", err, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_ar", {M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN}, 0);
        check_eq("arst_r_s", {M_AXI_RREADY, m_tvalid, m_tlast}, 0);
        check_eq("arst_tdata", m_tdata, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("arst_ready_back", cmd_ready, 1);
        run_cmd(32'h1000_0000, 40, 1'b1, 0, 0);
        check_s1_log();

        check_eq("rready_low_outstanding", 64'(rready_viol), 0);
        check_eq("credit_overrun", 64'(credit_viol), 0);
        check_eq("stream_hold", 64'(hold_viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
